// File: rtl/bf_fetch_decode_if.sv
// Fetch/decode bundle: the program ROM port plus the opcode handshake towards control.
// The master side is the fetch/decode stage; the slave side is the ROM and control.
interface bf_fetch_decode_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              pc_dir;
    logic [2:0]        cmd;

    modport master (
        output prog_addr,
        output cmd_valid,
        output cmd,
        input  prog_data,
        input  cmd_ready,
        input  pc_dir
    );

    modport slave (
        input  prog_addr,
        input  cmd_valid,
        input  cmd,
        output prog_data,
        output cmd_ready,
        output pc_dir
    );
endinterface

// File: rtl/bf_fetch_decode.sv
// BF instruction fetch/decode: owns the PC, reads the ASCII program ROM, skips
// non-command bytes and offers 3-bit opcodes to the control FSM over valid/ready.
module bf_fetch_decode #(
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    bf_fetch_decode_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              pc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_VALID,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              dir_q, dir_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic              is_cmd;
    logic [2:0]        dec_op;
    logic              step_dir;
    logic              step_oob;
    logic [ADDR_W-1:0] step_pc;

    always_comb begin
        is_cmd = 1'b1;
        dec_op = 3'd0;
        case (bus.prog_data)
            8'h3C:   dec_op = 3'd0;
            8'h3E:   dec_op = 3'd1;
            8'h2B:   dec_op = 3'd2;
            8'h2D:   dec_op = 3'd3;
            8'h5B:   dec_op = 3'd4;
            8'h5D:   dec_op = 3'd5;
            8'h2E:   dec_op = 3'd6;
            8'h2C:   dec_op = 3'd7;
            default: is_cmd = 1'b0;
        endcase
    end

    // Accepts step in the direction control gives now; skips reuse the last accepted one.
    assign step_dir = (state_q == S_VALID) ? bus.pc_dir : dir_q;
    assign step_oob = step_dir ? (pc_q == '0) : (pc_q == LAST_ADDR);
    assign step_pc  = step_dir ? (pc_q - ADDR_W'(1)) : (pc_q + ADDR_W'(1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cmd_d    = cmd_q;
        dir_d    = dir_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (is_cmd) begin
                    cmd_d   = dec_op;
                    state_d = S_VALID;
                end else if (bus.prog_data == 8'h00) begin
                    halted_d = 1'b1;
                    err_d    = 1'b0;
                    state_d  = S_HALT;
                end else if (step_oob) begin
                    halted_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = step_pc;
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                if (bus.cmd_ready) begin
                    dir_d = bus.pc_dir;
                    if (step_oob) begin
                        halted_d = 1'b1;
                        err_d    = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = step_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                    pc_d     = '0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cmd_q    <= 3'd0;
            dir_q    <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cmd_q    <= cmd_d;
            dir_q    <= dir_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // The ROM address is the PC register itself, so it is registered and always equal to pc.
    assign bus.prog_addr = pc_q;
    assign bus.cmd_valid = (state_q == S_VALID);
    assign bus.cmd       = cmd_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign pc_err        = err_q;

endmodule

// File: tb/tb_bf_fetch_decode.sv
// Directed bench for bf_fetch_decode: a full-size instance and a 4-byte-program
// instance, each fed by a synchronous ROM model loaded from ASCII strings.
module tb_bf_fetch_decode;

    logic       clk;
    logic       resetn;
    logic       start0, start1;
    logic [7:0] pc0, pc1;
    logic       halted0, halted1, err0, err1;
    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];
    int         checks;
    int         passed;

    bf_fetch_decode_if #(.ADDR_W(8)) bus0 ();
    bf_fetch_decode_if #(.ADDR_W(8)) bus1 ();

    bf_fetch_decode #(.ADDR_W(8), .PROG_DEPTH(256)) dut0 (
        .clk(clk), .resetn(resetn), .start(start0), .bus(bus0.master),
        .pc(pc0), .halted(halted0), .pc_err(err0)
    );

    bf_fetch_decode #(.ADDR_W(8), .PROG_DEPTH(4)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .bus(bus1.master),
        .pc(pc1), .halted(halted1), .pc_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROMs: data appears one cycle after the address.
    always @(posedge clk) begin
        bus0.prog_data <= rom0[bus0.prog_addr];
        bus1.prog_data <= rom1[bus1.prog_addr];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load0(input string s);
        for (int i = 0; i < 256; i++) rom0[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom0[i] = s[i];
    endtask

    task automatic load1(input string s);
        for (int i = 0; i < 256; i++) rom1[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom1[i] = s[i];
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic do_start0();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
    endtask

    task automatic accept0(input logic dir);
        bus0.pc_dir    = dir;
        bus0.cmd_ready = 1'b1;
        tick(1);
        bus0.cmd_ready = 1'b0;
    endtask

    task automatic accept1(input logic dir);
        bus1.pc_dir    = dir;
        bus1.cmd_ready = 1'b1;
        tick(1);
        bus1.cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.cmd_ready = 1'b0;
        bus0.pc_dir    = 1'b0;
        bus1.cmd_ready = 1'b0;
        bus1.pc_dir    = 1'b0;
        load0("");
        load1("");
        tick(2);
        checks++; if (pc0 !== 8'd0) $display("[TB] FAIL rst_pc: got %0d expected 0", pc0); else passed++;
        checks++; if (bus0.prog_addr !== 8'd0) $display("[TB] FAIL rst_addr: got %0d expected 0", bus0.prog_addr); else passed++;
        checks++; if (bus0.cmd !== 3'd0) $display("[TB] FAIL rst_cmd: got %0d expected 0", bus0.cmd); else passed++;
        checks++; if ({bus0.cmd_valid, halted0, err0} !== 3'b000) $display("[TB] FAIL rst_flags: got %b expected 000", {bus0.cmd_valid, halted0, err0}); else passed++;
        checks++; if ({bus1.cmd_valid, halted1, err1, pc1} !== 11'd0) $display("[TB] FAIL rst_dut1: got %h expected 0", {bus1.cmd_valid, halted1, err1, pc1}); else passed++;
        resetn = 1'b1;
        bus0.cmd_ready = 1'b1;
        tick(3);
        bus0.cmd_ready = 1'b0;
        checks++; if ({bus0.cmd_valid, pc0} !== 9'd0) $display("[TB] FAIL idle_no_start: got %h expected 0", {bus0.cmd_valid, pc0}); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        load0("+.");
        do_start0();
        tick(1);
        checks++; if (bus0.cmd_valid !== 1'b0) $display("[TB] FAIL t1_early_valid: got %b expected 0", bus0.cmd_valid); else passed++;
        tick(1);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd2, 8'd0}) $display("[TB] FAIL t1_first: got valid=%b cmd=%0d pc=%0d expected 1/2/0", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        tick(1);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd2, 8'd0}) $display("[TB] FAIL t1_hold: got valid=%b cmd=%0d pc=%0d expected 1/2/0", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b0);
        tick(1);
        checks++; if (bus0.cmd_valid !== 1'b0) $display("[TB] FAIL t1_gap: got %b expected 0", bus0.cmd_valid); else passed++;
        tick(1);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd6, 8'd1}) $display("[TB] FAIL t1_second: got valid=%b cmd=%0d pc=%0d expected 1/6/1", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b0);
        tick(2);
        checks++; if ({bus0.cmd_valid, halted0, err0, pc0} !== {3'b010, 8'd2}) $display("[TB] FAIL t1_halt: got valid=%b halted=%b err=%b pc=%0d expected 0/1/0/2", bus0.cmd_valid, halted0, err0, pc0); else passed++;
        bus0.cmd_ready = 1'b1;
        tick(2);
        bus0.cmd_ready = 1'b0;
        checks++; if ({bus0.cmd_valid, halted0, pc0} !== {2'b01, 8'd2}) $display("[TB] FAIL t1_halt_ready: got valid=%b halted=%b pc=%0d expected 0/1/2", bus0.cmd_valid, halted0, pc0); else passed++;
    endtask

    task automatic test_skip();
        do_reset();
        load0("a b\n>");
        do_start0();
        tick(9);
        checks++; if (bus0.cmd_valid !== 1'b0) $display("[TB] FAIL t2_early_valid: got %b expected 0", bus0.cmd_valid); else passed++;
        tick(1);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd1, 8'd4}) $display("[TB] FAIL t2_skip: got valid=%b cmd=%0d pc=%0d expected 1/1/4", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
    endtask

    task automatic test_backward();
        do_reset();
        load0("[+]");
        do_start0();
        tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd4, 8'd0}) $display("[TB] FAIL t3_open: got valid=%b cmd=%0d pc=%0d expected 1/4/0", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b0); tick(2);
        accept0(1'b0); tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd5, 8'd2}) $display("[TB] FAIL t3_close: got valid=%b cmd=%0d pc=%0d expected 1/5/2", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd5, 8'd2}) $display("[TB] FAIL t3_start_ignored: got valid=%b cmd=%0d pc=%0d expected 1/5/2", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b1); tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd2, 8'd1}) $display("[TB] FAIL t3_back1: got valid=%b cmd=%0d pc=%0d expected 1/2/1", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b1); tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd4, 8'd0}) $display("[TB] FAIL t3_back0: got valid=%b cmd=%0d pc=%0d expected 1/4/0", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
        accept0(1'b0); tick(2);
        accept0(1'b0); tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd5, 8'd2}) $display("[TB] FAIL t3_forward: got valid=%b cmd=%0d pc=%0d expected 1/5/2", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        load0("[");
        do_start0();
        tick(2);
        accept0(1'b1);
        checks++; if ({bus0.cmd_valid, halted0, err0, pc0} !== {3'b011, 8'd0}) $display("[TB] FAIL t4_underflow: got valid=%b halted=%b err=%b pc=%0d expected 0/1/1/0", bus0.cmd_valid, halted0, err0, pc0); else passed++;
        bus0.pc_dir = 1'b0;
        do_start0();
        tick(2);
        checks++; if ({bus0.cmd_valid, halted0, err0, bus0.cmd, pc0} !== {3'b100, 3'd4, 8'd0}) $display("[TB] FAIL t4_restart: got valid=%b halted=%b err=%b cmd=%0d pc=%0d expected 1/0/0/4/0", bus0.cmd_valid, halted0, err0, bus0.cmd, pc0); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        load1("++++");
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(2);
        checks++; if ({bus1.cmd_valid, pc1} !== {1'b1, 8'd0}) $display("[TB] FAIL t5_first: got valid=%b pc=%0d expected 1/0", bus1.cmd_valid, pc1); else passed++;
        for (int k = 1; k <= 3; k++) begin
            accept1(1'b0);
            tick(2);
            checks++; if ({bus1.cmd_valid, pc1} !== {1'b1, 8'(k)}) $display("[TB] FAIL t5_step%0d: got valid=%b pc=%0d expected 1/%0d", k, bus1.cmd_valid, pc1, k); else passed++;
        end
        accept1(1'b0);
        checks++; if ({bus1.cmd_valid, halted1, err1, pc1} !== {3'b011, 8'd3}) $display("[TB] FAIL t5_overflow: got valid=%b halted=%b err=%b pc=%0d expected 0/1/1/3", bus1.cmd_valid, halted1, err1, pc1); else passed++;
    endtask

    task automatic test_back_to_back();
        int         vcount;
        logic [7:0] vpc [3];
        do_reset();
        load0("+-<");
        vcount = 0;
        bus0.pc_dir    = 1'b0;
        bus0.cmd_ready = 1'b1;
        do_start0();
        for (int k = 0; k < 12; k++) begin
            if (bus0.cmd_valid === 1'b1) begin
                if (vcount < 3) vpc[vcount] = pc0;
                vcount++;
            end
            tick(1);
        end
        bus0.cmd_ready = 1'b0;
        checks++; if (vcount !== 3) $display("[TB] FAIL t6_valid_count: got %0d expected 3", vcount); else passed++;
        checks++; if ({vpc[0], vpc[1], vpc[2]} !== {8'd0, 8'd1, 8'd2}) $display("[TB] FAIL t6_valid_pcs: got %0d,%0d,%0d expected 0,1,2", vpc[0], vpc[1], vpc[2]); else passed++;
        checks++; if ({halted0, err0, pc0} !== {2'b10, 8'd3}) $display("[TB] FAIL t6_end: got halted=%b err=%b pc=%0d expected 1/0/3", halted0, err0, pc0); else passed++;
        do_start0();
        tick(2);
        accept0(1'b0);
        tick(1);
        checks++; if ({bus0.cmd_valid, pc0} !== {1'b0, 8'd1}) $display("[TB] FAIL t6_pre_reset: got valid=%b pc=%0d expected 0/1", bus0.cmd_valid, pc0); else passed++;
        resetn = 1'b0;
        #2;
        checks++; if ({pc0, bus0.prog_addr, bus0.cmd} !== 19'd0) $display("[TB] FAIL t6_async_regs: got pc=%0d addr=%0d cmd=%0d expected 0/0/0", pc0, bus0.prog_addr, bus0.cmd); else passed++;
        checks++; if ({bus0.cmd_valid, halted0, err0} !== 3'b000) $display("[TB] FAIL t6_async_flags: got %b expected 000", {bus0.cmd_valid, halted0, err0}); else passed++;
        tick(1);
        resetn = 1'b1;
        tick(3);
        checks++; if ({bus0.cmd_valid, pc0} !== 9'd0) $display("[TB] FAIL t6_discard: got valid=%b pc=%0d expected 0/0", bus0.cmd_valid, pc0); else passed++;
        do_start0();
        tick(2);
        checks++; if ({bus0.cmd_valid, bus0.cmd, pc0} !== {1'b1, 3'd2, 8'd0}) $display("[TB] FAIL t6_rerun: got valid=%b cmd=%0d pc=%0d expected 1/2/0", bus0.cmd_valid, bus0.cmd, pc0); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_skip();
        test_backward();
        test_underflow();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
